// File: rtl/mem_if_pkg.sv
// Shared types and constants for the processor-side memory initiator.
package mem_if_pkg;

  typedef enum logic [1:0] {
    KIND_FETCH = 2'd0,
    KIND_LOAD  = 2'd1,
    KIND_STORE = 2'd2,
    KIND_RSVD  = 2'd3
  } req_kind_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

endpackage

// File: rtl/mem_align_check.sv
// Combinational legality check for a request: kind, funct3 and the
// low address bits decide whether the memory may be touched at all.
module mem_align_check
  import mem_if_pkg::*;
(
  input  logic [1:0] kind_i,
  input  logic [2:0] funct3_i,
  input  logic [1:0] addr_lo_i,
  output logic       fault_o
);

  always_comb begin
    fault_o = 1'b0;
    case (kind_i)
      KIND_FETCH: fault_o = (addr_lo_i != 2'b00);
      KIND_LOAD, KIND_STORE: begin
        case (funct3_i)
          F3_B, F3_BU: fault_o = 1'b0;
          F3_H, F3_HU: fault_o = addr_lo_i[0];
          F3_W:        fault_o = (addr_lo_i != 2'b00);
          default:     fault_o = 1'b1;
        endcase
        // Stores have no unsigned variants.
        if ((kind_i == KIND_STORE) && funct3_i[2]) fault_o = 1'b1;
      end
      default: fault_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_initiator.sv
// Bus master between the core control FSM and the RV32I memory: one
// request at a time, timed for the memory's 1-cycle registered read.
module mem_initiator
  import mem_if_pkg::*;
#(
  parameter logic [2:0] FETCH_F3 = 3'b010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_kind,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_fault,
  output logic        write_mem,
  output logic [2:0]  funct3,
  output logic [31:0] write_address,
  output logic [31:0] write_data,
  output logic [31:0] read_address,
  input  logic [31:0] read_data
);

  state_t      state_q, state_d;
  req_kind_t   kind_q;
  logic [2:0]  busF3_q;
  logic [31:0] busAddr_q;
  logic [31:0] busWdata_q;
  logic [31:0] rspData_q;
  logic        rspFault_q;

  logic        accept;
  logic        reqFault;
  logic [2:0]  reqF3Eff;

  mem_align_check u_align (
    .kind_i    (req_kind),
    .funct3_i  (req_funct3),
    .addr_lo_i (req_addr[1:0]),
    .fault_o   (reqFault)
  );

  assign accept   = (state_q == ST_IDLE) && req_valid;
  assign reqF3Eff = (req_kind == KIND_FETCH) ? FETCH_F3 : req_funct3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = reqFault ? ST_RESP : ST_ISSUE;
      ST_ISSUE:   state_d = (kind_q == KIND_STORE) ? ST_RESP : ST_CAPTURE;
      ST_CAPTURE: state_d = ST_RESP;
      ST_RESP:    if (rsp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Bus registers only move on a legal accept, so a faulting request
  // leaves the memory-side pins exactly as the previous access left them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kind_q     <= KIND_FETCH;
      busF3_q    <= 3'b000;
      busAddr_q  <= 32'h0;
      busWdata_q <= 32'h0;
      rspData_q  <= 32'h0;
      rspFault_q <= 1'b0;
    end else begin
      if (accept) begin
        kind_q     <= req_kind_t'(req_kind);
        rspData_q  <= 32'h0;
        rspFault_q <= reqFault;
        if (!reqFault) begin
          busF3_q    <= reqF3Eff;
          busAddr_q  <= req_addr;
          busWdata_q <= req_wdata;
        end
      end
      if (state_q == ST_CAPTURE) rspData_q <= read_data;
      if ((state_q == ST_RESP) && rsp_ready) rspFault_q <= 1'b0;
    end
  end

  assign req_ready     = (state_q == ST_IDLE);
  assign rsp_valid     = (state_q == ST_RESP);
  assign rsp_data      = rspData_q;
  assign rsp_fault     = rspFault_q;
  assign write_mem     = (state_q == ST_ISSUE) && (kind_q == KIND_STORE);
  assign funct3        = busF3_q;
  assign write_address = busAddr_q;
  assign read_address  = busAddr_q;
  assign write_data    = busWdata_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Randomized self-checking bench for mem_initiator with a byte-array memory
// model and a request-level reference model.
module tb_mem_initiator;

  localparam int MEMSIZE = 1024;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_kind;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_fault;
  logic        write_mem;
  logic [2:0]  funct3;
  logic [31:0] write_address;
  logic [31:0] write_data;
  logic [31:0] read_address;
  logic [31:0] read_data;

  int checks = 0;
  int errors = 0;
  int seed;
  int wmCount = 0;
  logic initMem;

  logic [7:0] memBytes [0:MEMSIZE-1];
  logic [7:0] refBytes [0:MEMSIZE-1];

  mem_initiator #(.FETCH_F3(3'b010)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_kind      (req_kind),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_fault     (rsp_fault),
    .write_mem     (write_mem),
    .funct3        (funct3),
    .write_address (write_address),
    .write_data    (write_data),
    .read_address  (read_address),
    .read_data     (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] initByte(input int i);
    return 8'((i * 37 + seed) ^ (i >> 2));
  endfunction

  function automatic logic [31:0] assemble(input logic [2:0] f3, input logic [7:0] b0,
                                           input logic [7:0] b1, input logic [7:0] b2,
                                           input logic [7:0] b3);
    case (f3[1:0])
      2'd0:    return f3[2] ? {24'h0, b0} : {{24{b0[7]}}, b0};
      2'd1:    return f3[2] ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  function automatic logic [31:0] memRead(input logic [2:0] f3, input logic [31:0] addr);
    logic [9:0] a;
    a = addr[9:0];
    return assemble(f3, memBytes[a], memBytes[a + 10'd1], memBytes[a + 10'd2], memBytes[a + 10'd3]);
  endfunction

  function automatic logic [31:0] refRead(input logic [2:0] f3, input logic [31:0] addr);
    logic [9:0] a;
    a = addr[9:0];
    return assemble(f3, refBytes[a], refBytes[a + 10'd1], refBytes[a + 10'd2], refBytes[a + 10'd3]);
  endfunction

  // Memory device: byte-lane writes on write_mem, registered read one cycle later.
  always @(posedge clk) begin
    if (initMem) begin
      for (int i = 0; i < MEMSIZE; i++) memBytes[i] <= initByte(i);
    end else if (write_mem) begin
      for (int i = 0; i < 4; i++)
        if (i < (1 << funct3[1:0]))
          memBytes[write_address[9:0] + 10'(i)] <= write_data[8*i +: 8];
      wmCount <= wmCount + 1;
    end
    read_data <= memRead(funct3, read_address);
  end

  function automatic bit isIllegal(input int kind, input logic [2:0] f3, input logic [31:0] addr);
    int size;
    if (kind == 3) return 1'b1;
    if (kind == 0) return (addr % 4) != 0;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (kind == 2 && f3 >= 3'd4) return 1'b1;
    size = 1 << f3[1:0];
    return (addr % size) != 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_rsp_fault"}, 32'(rsp_fault), 32'd0);
    checkOutput({tag, "_rsp_data"}, rsp_data, 32'h0);
    checkOutput({tag, "_write_mem"}, 32'(write_mem), 32'd0);
    checkOutput({tag, "_funct3"}, 32'(funct3), 32'd0);
    checkOutput({tag, "_read_address"}, read_address, 32'h0);
    checkOutput({tag, "_write_address"}, write_address, 32'h0);
    checkOutput({tag, "_write_data"}, write_data, 32'h0);
  endtask

  // One complete transaction, starting and ending at a negedge in IDLE.
  task automatic applyStimulus(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input int hold,
                               output logic [31:0] gotData);
    bit          expFault;
    int          expLat;
    int          cycles;
    int          wmBefore;
    logic [2:0]  effF3;
    logic [31:0] expData;
    logic [31:0] prevRdAddr;

    expFault   = isIllegal(kind, f3, addr);
    effF3      = (kind == 0) ? 3'b010 : f3;
    expLat     = expFault ? 1 : (kind == 2) ? 2 : 3;
    expData    = (expFault || kind == 2) ? 32'h0 : refRead(effF3, addr);
    wmBefore   = wmCount;
    prevRdAddr = read_address;

    checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_kind   = 2'(kind);
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    rsp_ready  = 1'b0;
    @(negedge clk);
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_wdata  = $urandom;
    cycles = 1;
    while (!rsp_valid && cycles < 12) begin
      checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
      if (cycles == 1) begin
        checkOutput("issue_funct3", 32'(funct3), 32'(effF3));
        checkOutput("issue_read_address", read_address, addr);
        checkOutput("issue_write_address", write_address, addr);
        checkOutput("issue_write_mem", 32'(write_mem), (kind == 2) ? 32'd1 : 32'd0);
        if (kind == 2) checkOutput("issue_write_data", write_data, wdata);
      end else if (cycles == 2) begin
        checkOutput("capture_funct3", 32'(funct3), 32'(effF3));
        checkOutput("capture_read_address", read_address, addr);
        checkOutput("capture_write_mem", 32'(write_mem), 32'd0);
      end
      @(negedge clk);
      cycles++;
    end
    checkOutput("latency", 32'(cycles), 32'(expLat));
    checkOutput("rsp_fault", 32'(rsp_fault), 32'(expFault));
    checkOutput("rsp_data", rsp_data, expData);
    if (expFault) checkOutput("fault_read_address", read_address, prevRdAddr);
    if (kind == 2 && !expFault)
      for (int i = 0; i < (1 << f3[1:0]); i++) refBytes[addr[9:0] + 10'(i)] = wdata[8*i +: 8];
    checkOutput("write_pulses", 32'(wmCount - wmBefore), (kind == 2 && !expFault) ? 32'd1 : 32'd0);
    gotData = rsp_data;

    for (int i = 0; i < hold; i++) begin
      req_valid  = 1'b1;
      req_kind   = 2'($urandom_range(0, 2));
      req_funct3 = 3'b010;
      req_addr   = 32'h0;
      @(negedge clk);
      checkOutput("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("hold_rsp_data", rsp_data, expData);
      checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    checkOutput("done_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("done_req_ready", 32'(req_ready), 32'd1);
    checkOutput("done_rsp_fault", 32'(rsp_fault), 32'd0);
  endtask

  initial begin : main
    logic [31:0] got;
    int          kind;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] bases [5];

    bases[0] = 32'h0000_0000; bases[1] = 32'h0000_0100; bases[2] = 32'h0000_0200;
    bases[3] = 32'h0000_03F0; bases[4] = 32'hFFFF_FFF0;

    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_kind = 2'd0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    seed = int'($urandom);
    initMem = 1'b1;
    for (int i = 0; i < MEMSIZE; i++) refBytes[i] = initByte(i);
    repeat (2) @(negedge clk);
    initMem = 1'b0;
    checkResetValues("reset");
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(2, 3'b010, 32'h100, 32'hDEADBEEF, 0, got);
    applyStimulus(1, 3'b010, 32'h100, 32'h0, 0, got);
    checkOutput("tp_load_word", got, 32'hDEADBEEF);
    applyStimulus(2, 3'b000, 32'h203, 32'h0000_00A5, 0, got);
    applyStimulus(1, 3'b100, 32'h203, 32'h0, 0, got);
    checkOutput("tp_load_bu", got, 32'h0000_00A5);
    applyStimulus(1, 3'b000, 32'h203, 32'h0, 0, got);
    checkOutput("tp_load_b", got, 32'hFFFF_FFA5);
    applyStimulus(1, 3'b010, 32'h102, 32'h0, 0, got);
    applyStimulus(0, 3'b000, 32'h0, 32'h0, 0, got);
    applyStimulus(1, 3'b001, 32'h102, 32'h0, 5, got);
    applyStimulus(1, 3'b010, 32'hFFFF_FFF8, 32'h0, 1, got);

    // Reset in the middle of a store's ISSUE cycle must abort the write.
    req_valid = 1'b1; req_kind = 2'd2; req_funct3 = 3'b010;
    req_addr = 32'h10; req_wdata = ~refRead(3'b010, 32'h10);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("abort_pre_write_mem", 32'(write_mem), 32'd1);
    reset = 1'b1;
    #1;
    checkResetValues("abort");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_req_ready", 32'(req_ready), 32'd1);
    checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    applyStimulus(1, 3'b010, 32'h10, 32'h0, 0, got);

    for (int n = 0; n < 150; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      kind = (r < 2) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
      if ($urandom_range(0, 9) < 7) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100; default: f3 = 3'b101;
        endcase
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      addr = bases[$urandom_range(0, 4)] + 32'($urandom_range(0, 15));
      applyStimulus(kind, f3, addr, $urandom, int'($urandom_range(0, 3)), got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
- Processor-side bus master for the RV32I memory module.
- Accepts one fetch/load/store request at a time from the core over a valid/ready handshake and checks alignment and funct3 legality.
- Drives the memory's write_mem/funct3/address/data pins with the correct timing for its 1-cycle registered read latency.
- Returns read data or a store acknowledge over a valid/ready response channel.
- Sits between the core control FSM and memory.

Parameters:
- FETCH_F3, 3'b010, funct3 value forced onto the memory bus for instruction fetches.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  core presents a request
- req_ready  output  1  block can accept a request (high only in IDLE)
- req_kind  input  2  0=FETCH, 1=LOAD, 2=STORE, 3=reserved (faults)
- req_funct3  input  3  RV32I load/store funct3 (ignored for FETCH)
- req_addr  input  32  byte address
- req_wdata  input  32  store data (rs2), unshifted
- rsp_valid  output  1  response available
- rsp_ready  input  1  core consumes response
- rsp_data  output  32  load/fetch data, already extended by memory; 0 for stores and faults
- rsp_fault  output  1  request rejected (misaligned or illegal), no memory access made
- write_mem  output  1  memory write strobe
- funct3  output  3  funct3 to memory
- write_address  output  32  memory write address
- write_data  output  32  memory write data
- read_address  output  32  memory read address
- read_data  input  32  memory read data, valid the cycle after the address is presented

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_fault=0, rsp_data=0, write_mem=0, funct3=0, all addresses and write_data=0.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE, on req_valid&&req_ready: register kind, funct3 (FETCH_F3 if FETCH), addr and wdata.
  - Legal request: go to ISSUE.
  - Illegal request: go to RESP with rsp_fault=1 and rsp_data=0.
- Illegal requests:
  - kind=3.
  - funct3 in {3'b011, 3'b110, 3'b111}.
  - STORE with funct3[2]=1.
  - Word access with addr[1:0]!=0.
  - Half access with addr[0]!=0.
  - FETCH with addr[1:0]!=0.
- ISSUE: read_address and write_address = registered addr; funct3 = registered funct3.
  - STORE: write_mem=1 for exactly this cycle, write_data = registered wdata unmodified (memory selects lanes); next state RESP.
  - FETCH/LOAD: write_mem=0; next state CAPTURE.
- CAPTURE: funct3 and read_address held. rsp_data <= read_data at the end of the cycle. Next state RESP.
- RESP: rsp_valid=1, with rsp_data/rsp_fault stable.
  - rsp_ready=1: rsp_valid deasserts next edge, state returns to IDLE, rsp_fault cleared.
  - Back-pressure: stay in RESP indefinitely.
- write_mem is combinational from state==ISSUE && kind==STORE only; never high in any other state.
- Latency, accept edge to rsp_valid high:
  - load/fetch: 3 cycles
  - store: 2 cycles
  - fault: 1 cycle
- Throughput: one request per 4 cycles minimum for loads, with rsp_ready held high.
- req_ready=0 outside IDLE. req_valid in other states is ignored and not latched.
- Memory-side outputs keep their last values in IDLE/RESP, except write_mem, which stays 0.
- Address range: unmapped or peripheral addresses (e.g. 0xFFFFFFF8) are not filtered; the memory's response is passed through.
- Reset mid-operation: state goes to IDLE immediately.
  - write_mem drops asynchronously; a store in ISSUE at reset assertion is aborted.
  - No response is produced for the in-flight request.
- Simultaneous rsp_ready and a new req_valid in RESP: the response completes; the request is accepted no earlier than the next cycle (IDLE).

Decomposition:
- Package mem_if_pkg:
  - req_kind_t enum (KIND_FETCH, KIND_LOAD, KIND_STORE, KIND_RSVD).
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - state_t enum.
- One combinational sub-module, mem_align_check: inputs kind, funct3, addr[1:0]; output fault.

Test Plan:
- LOAD funct3=010 addr=0x100 with memory word 0xDEADBEEF -> rsp_valid 3 cycles after accept, rsp_data=0xDEADBEEF, rsp_fault=0.
- STORE funct3=000 addr=0x203 wdata=0x000000A5 -> write_mem high exactly one cycle, write_address=0x203, funct3=000. A subsequent LOAD funct3=100 addr=0x203 returns 0x000000A5; funct3=000 returns 0xFFFFFFA5.
- LOAD funct3=010 addr=0x102 -> rsp_fault=1 after 1 cycle, write_mem never asserted, read_address unchanged.
- FETCH with req_funct3=000 addr=0x0 -> bus funct3=010 during ISSUE/CAPTURE, rsp_data = full word at 0x0.
- rsp_ready held low 5 cycles after a LOAD -> rsp_valid and rsp_data stable, req_ready=0 throughout, second req_valid ignored; the request is accepted only after the handshake.
- Assert reset during ISSUE of STORE to 0x10 -> write_mem 0 immediately, memory at 0x10 unchanged, all outputs at reset values, req_ready=1 after release.
